j1_io_uart: RTL
===============

// Module: j1_io_uart
// PURPOSE
//  Memory-mapped UART peripheral answering the J1 core's IO bus (io_rd/io_wr/io_addr/io_dout/io_din).
//  Provides 8N1 transmit and receive, status/control registers and a level interrupt for the core's
//  interrupt_request input. Several IO peripherals share the bus; read data is OR-combined at the top level.
// PARAMETERS
//  CLK_HZ      100_000_000  clk frequency in Hz
//  BAUD        115200       line rate; DIV = CLK_HZ/BAUD (integer, >= 4), counter width $clog2(DIV)
//  BASE_ADDR   16'h1000     byte address of register 0; registers at BASE+0, +2, +4
//  FIFO_DEPTH  16           RX FIFO entries, power of two (used only with J1_UART_RX_FIFO_EN)
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  resetq     in   1   asynchronous, active-low reset
//  io_rd      in   1   core read strobe, single cycle
//  io_wr      in   1   core write strobe, single cycle
//  io_addr    in   16  byte address
//  io_dout    in   16  write data from core
//  io_din     out  16  read data to core; combinational; 16'h0000 unless io_rd and address hit
//  irq        out  1   level interrupt request to core
//  rxd        in   1   serial input, asynchronous, idle high
//  txd        out  1   serial output, idle high
// BEHAVIOUR
//  Reset: txd=1, irq=0, io_din=0, FIFO empty, all status/control bits 0, both FSMs IDLE.
//  Registers (hit = io_addr == BASE_ADDR+offset, full 16-bit compare):
//   +0 DATA  wr: io_dout[7:0] to TX holding reg if tx_ready, else dropped (no flag).
//            rd: {8'h00, rx head}; pop on the same posedge if rx_valid. Empty read returns 16'h0000.
//   +2 STAT  rd: {12'h0, frame_err, rx_overrun, tx_ready, rx_valid}; wr: bits [3:2] write-1-to-clear.
//   +4 CTRL  rd/wr: {14'h0, tx_ie, rx_ie}.
//  Read latency: zero; io_din valid combinationally during the io_rd cycle; side effects at the closing edge.
//  irq = (rx_ie & rx_valid) | (tx_ie & tx_ready), registered (1 cycle after cause); cleared by the cause.
//  TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE; each state lasts DIV clocks.
//   Holding reg loads shifter on entry to START; tx_ready = holding empty. Back-to-back bytes: no idle gap.
//  RX: 2-flop synchroniser on rxd. IDLE -> (sync low) START: wait DIV/2, resample; high = false start -> IDLE.
//   DATA: 8 samples at DIV spacing; STOP: sample after DIV; low -> frame_err set, byte discarded.
//   Valid byte pushed on STOP; FIFO full -> byte dropped, rx_overrun set.
//  Simultaneous events: push+pop on full FIFO both succeed, no overrun; hardware error set beats W1C clear;
//   DATA write in the cycle the shifter takes the holding byte is accepted.
//  Reset mid-frame: txd returns to 1 immediately (async), partially received byte lost.
//  io_wr and io_rd never asserted together; behaviour undefined if they are.
// CONFIGURATION
//  J1_UART_RX_FIFO_EN defined: RX FIFO of FIFO_DEPTH bytes, rx_valid = not empty.
//  Undefined: single-byte RX holding reg; FIFO_DEPTH ignored; second byte before pop -> rx_overrun, new byte dropped.
// STRUCTURE
//  Shared package j1_io_pkg: register offsets (DATA/STAT/CTRL), STAT and CTRL bit positions, FSM state encodings
//  reused by later IO peripherals.
//  One sub-module: j1_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/head), instantiated only under the macro.
// TESTING (CLK_HZ=16, BAUD=1 -> DIV=16 unless stated)
//  1 Reset -> txd=1, irq=0; rd STAT -> 16'h0002 (tx_ready only).
//  2 wr DATA 16'h00A5 -> txd low 16 clk, then 1,0,1,0,0,1,0,1 at 16 clk each, stop high; STAT=0000 during, 0002 after holding empties.
//  3 Drive rxd frame 8'h3C -> STAT bit0=1 after stop sample; rd DATA -> 16'h003C, next rd STAT bit0=0.
//  4 With FIFO: 17 frames unread -> STAT bit2=1, 16 reads return bytes in order; wr STAT 16'h0004 -> bit2 cleared.
//  5 Frame with stop bit low -> frame_err=1, rx_valid=0; rxd low pulse of 4 clk -> no state change (false start).
//  6 wr CTRL 16'h0001, receive byte -> irq=1 one clk after push; rd DATA -> irq=0 next clk; rd unmapped addr -> io_din=0.

Source files
------------

// File: rtl/j1_io_pkg.sv
// j1_io_pkg: register map, status/control bit positions and serial FSM states shared by J1 IO peripherals
package j1_io_pkg;
   localparam logic [15:0] OFF_DATA = 16'h0000;
   localparam logic [15:0] OFF_STAT = 16'h0002;
   localparam logic [15:0] OFF_CTRL = 16'h0004;
   localparam int STAT_RXV  = 0;
   localparam int STAT_TXR  = 1;
   localparam int STAT_OVR  = 2;
   localparam int STAT_FE   = 3;
   localparam int CTRL_RXIE = 0;
   localparam int CTRL_TXIE = 1;
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_e;
endpackage

// File: rtl/j1_sync_fifo.sv
// j1_sync_fifo: synchronous FIFO with combinational head; push into a full FIFO succeeds only alongside a pop
module j1_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0] wp_q, wp_d, rp_q, rp_d;
   logic do_push, do_pop;
   assign empty_o = wp_q == rp_q;
   assign full_o  = (wp_q[AW-1:0] == rp_q[AW-1:0]) & (wp_q[AW] != rp_q[AW]);
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;
   assign wp_d    = wp_q + {{AW{1'b0}}, do_push};
   assign rp_d    = rp_q + {{AW{1'b0}}, do_pop};
   assign head_o  = mem_q[rp_q[AW-1:0]];
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end
   // When full, the slot being written is the one popped this same edge
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
   end
endmodule

// File: rtl/j1_io_uart.sv
// j1_io_uart: memory-mapped 8N1 UART on the J1 IO bus (DATA/STAT/CTRL, level irq).
// Define J1_UART_RX_FIFO_EN for an RX FIFO of FIFO_DEPTH bytes instead of a single holding byte.
module j1_io_uart
   import j1_io_pkg::*;
#(
   parameter int          CLK_HZ     = 100_000_000,
   parameter int          BAUD       = 115200,
   parameter logic [15:0] BASE_ADDR  = 16'h1000,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [15:0] io_addr,
   input  logic [15:0] io_dout,
   output logic [15:0] io_din,
   output logic        irq,
   input  logic        rxd,
   output logic        txd
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
   localparam logic [15:0] A_DATA = BASE_ADDR + OFF_DATA;
   localparam logic [15:0] A_STAT = BASE_ADDR + OFF_STAT;
   localparam logic [15:0] A_CTRL = BASE_ADDR + OFF_CTRL;

   if (DIV < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_cfg_err
      $error("j1_io_uart: DIV must be >= 4 and FIFO_DEPTH a power of two");
   end

   logic rd_data, rd_stat, rd_ctrl, wr_data, wr_stat, wr_ctrl;
   assign rd_data = io_rd & (io_addr == A_DATA);
   assign rd_stat = io_rd & (io_addr == A_STAT);
   assign rd_ctrl = io_rd & (io_addr == A_CTRL);
   assign wr_data = io_wr & (io_addr == A_DATA);
   assign wr_stat = io_wr & (io_addr == A_STAT);
   assign wr_ctrl = io_wr & (io_addr == A_CTRL);

   logic unused_dout;
   assign unused_dout = ^io_dout[15:8];

   uart_st_e tx_st_q, tx_st_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0] tx_bit_q, tx_bit_d;
   logic [7:0] tx_sh_q, tx_sh_d, hold_q, hold_d;
   logic hold_v_q, hold_v_d, txd_q, txd_d, tx_load, tx_tick, tx_ready, wr_accept;

   assign tx_ready  = ~hold_v_q;
   assign tx_tick   = tx_cnt_q == DIV_M1;
   assign wr_accept = wr_data & (~hold_v_q | tx_load);
   assign hold_d    = wr_accept ? io_dout[7:0] : hold_q;
   assign hold_v_d  = wr_accept | (hold_v_q & ~tx_load);

   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q + 1'b1;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      tx_load  = 1'b0;
      case (tx_st_q)
         ST_IDLE: begin
            tx_cnt_d = '0;
            if (hold_v_q) begin
               tx_load = 1'b1;
               tx_sh_d = hold_q;
               tx_st_d = ST_START;
            end
         end
         ST_START: if (tx_tick) begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            tx_st_d  = ST_DATA;
         end
         ST_DATA: if (tx_tick) begin
            tx_cnt_d = '0;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_st_d = ST_STOP;
         end
         ST_STOP: if (tx_tick) begin
            tx_cnt_d = '0;
            tx_load  = hold_v_q;
            tx_sh_d  = hold_v_q ? hold_q : tx_sh_q;
            tx_st_d  = hold_v_q ? ST_START : ST_IDLE;
         end
      endcase
      txd_d = tx_st_d == ST_START ? 1'b0 : tx_st_d == ST_DATA ? tx_sh_d[0] : 1'b1;
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         tx_st_q  <= ST_IDLE;
         tx_cnt_q <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
         hold_q   <= '0;
         hold_v_q <= 1'b0;
         txd_q    <= 1'b1;
      end else begin
         tx_st_q  <= tx_st_d;
         tx_cnt_q <= tx_cnt_d;
         tx_bit_q <= tx_bit_d;
         tx_sh_q  <= tx_sh_d;
         hold_q   <= hold_d;
         hold_v_q <= hold_v_d;
         txd_q    <= txd_d;
      end
   end
   assign txd = txd_q;

   uart_st_e rx_st_q, rx_st_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0] rx_bit_q, rx_bit_d;
   logic [7:0] rx_sh_q, rx_sh_d, rx_head;
   logic [1:0] rx_sync_q;
   logic rx_s, rx_push, fe_set, ovr_set, rx_valid, rx_pop;

   assign rx_s   = rx_sync_q[1];
   assign rx_pop = rd_data & rx_valid;

   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q + 1'b1;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      rx_push  = 1'b0;
      fe_set   = 1'b0;
      case (rx_st_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            if (!rx_s) rx_st_d = ST_START;
         end
         ST_START: if (rx_cnt_q == HALF_M1) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = rx_s ? ST_IDLE : ST_DATA;
         end
         ST_DATA: if (rx_cnt_q == DIV_M1) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_s, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = ST_STOP;
         end
         ST_STOP: if (rx_cnt_q == DIV_M1) begin
            rx_cnt_d = '0;
            rx_push  = rx_s;
            fe_set   = ~rx_s;
            rx_st_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_sync_q <= 2'b11;
         rx_st_q   <= ST_IDLE;
         rx_cnt_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
      end else begin
         rx_sync_q <= {rx_sync_q[0], rxd};
         rx_st_q   <= rx_st_d;
         rx_cnt_q  <= rx_cnt_d;
         rx_bit_q  <= rx_bit_d;
         rx_sh_q   <= rx_sh_d;
      end
   end

`ifdef J1_UART_RX_FIFO_EN
   logic fifo_full, fifo_empty;
   j1_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .resetq  (resetq),
      .push_i  (rx_push),
      .pop_i   (rx_pop),
      .din_i   (rx_sh_q),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (rx_head)
   );
   assign rx_valid = ~fifo_empty;
   assign ovr_set  = rx_push & fifo_full & ~rx_pop;
`else
   logic [7:0] rxb_q, rxb_d;
   logic rxb_v_q, rxb_v_d, rx_accept;
   // A byte arriving while the held one is popped replaces it rather than overrunning
   assign rx_accept = rx_push & (~rxb_v_q | rx_pop);
   assign rxb_d     = rx_accept ? rx_sh_q : rxb_q;
   assign rxb_v_d   = rx_accept | (rxb_v_q & ~rx_pop);
   assign ovr_set   = rx_push & ~rx_accept;
   assign rx_valid  = rxb_v_q;
   assign rx_head   = rxb_q;
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rxb_q   <= '0;
         rxb_v_q <= 1'b0;
      end else begin
         rxb_q   <= rxb_d;
         rxb_v_q <= rxb_v_d;
      end
   end
`endif

   logic fe_q, fe_d, ovr_q, ovr_d, irq_q, irq_d;
   logic [1:0] ie_q, ie_d;
   assign fe_d  = fe_set | (fe_q & ~(wr_stat & io_dout[STAT_FE]));
   assign ovr_d = ovr_set | (ovr_q & ~(wr_stat & io_dout[STAT_OVR]));
   assign ie_d  = wr_ctrl ? io_dout[1:0] : ie_q;
   assign irq_d = (ie_q[CTRL_RXIE] & rx_valid) | (ie_q[CTRL_TXIE] & tx_ready);

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         fe_q  <= 1'b0;
         ovr_q <= 1'b0;
         ie_q  <= '0;
         irq_q <= 1'b0;
      end else begin
         fe_q  <= fe_d;
         ovr_q <= ovr_d;
         ie_q  <= ie_d;
         irq_q <= irq_d;
      end
   end
   assign irq = irq_q;

   assign io_din = rd_data ? {8'h00, rx_valid ? rx_head : 8'h00}
                 : rd_stat ? {12'h000, fe_q, ovr_q, tx_ready, rx_valid}
                 : rd_ctrl ? {14'h0000, ie_q}
                 : 16'h0000;
endmodule
